data_path: RTL and testbench

DATA_PATH -- requirements
Module: data_path

---
 rtl/data_path.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_data_path.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/data_path.sv
// Single-cycle ARM-subset core: each instruction is decoded and executed combinationally,
// and register file, flags, interrupt masks and pc all update on the next rising clock edge.
module data_path (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] read_data,
    input  logic        irq,
    input  logic        firq,
    output logic [31:0] pc,
    output logic [31:0] addr_data,
    output logic [31:0] write_data,
    output logic        we
);

    localparam int unsigned     XLEN    = 32;
    localparam int unsigned     NREG    = 15;
    localparam logic [XLEN-1:0] VEC_SWI = 32'h0000_0008;
    localparam logic [XLEN-1:0] VEC_IRQ = 32'h0000_0018;
    localparam logic [XLEN-1:0] VEC_FIQ = 32'h0000_001C;
    localparam logic [3:0]      REG_LR  = 4'd14;
    localparam logic [3:0]      REG_PC  = 4'd15;

    typedef enum logic [3:0] {
        OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
        OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
    } alu_op_e;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] pc_q, pc_d;
    logic            n_q, z_q, c_q, v_q, n_d, z_d, c_d, v_d;
    logic            i_q, f_q, i_d, f_d;
    logic            wr_en;
    logic [3:0]      wr_idx;
    logic [XLEN-1:0] wr_val;

    logic [3:0]      rn_idx, rd_idx, rm_idx;
    logic [XLEN-1:0] pc_plus4, pc_plus8, rn_val, rd_val, rm_val;
    logic            is_bx, is_dp, is_mem, is_br, is_swi, is_cmp_class;
    logic            cond_ok, take_fiq, take_irq;

    logic [XLEN-1:0] imm32, op2, mem_addr;
    logic [4:0]      rot, shamt;
    logic [XLEN:0]   sh_tmp;
    logic            sh_c;

    alu_op_e         alu_op;
    logic [XLEN-1:0] add_x, add_y, logic_res, alu_res;
    logic [XLEN:0]   sum;
    logic            add_cin, arith, alu_c, alu_v;

    assign rn_idx   = instr[19:16];
    assign rd_idx   = instr[15:12];
    assign rm_idx   = instr[3:0];
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_plus8 = pc_q + 32'd8;

    // r15 as an operand reads as pc+8
    assign rn_val = (rn_idx == REG_PC) ? pc_plus8 : regs_q[rn_idx];
    assign rd_val = (rd_idx == REG_PC) ? pc_plus8 : regs_q[rd_idx];
    assign rm_val = (rm_idx == REG_PC) ? pc_plus8 : regs_q[rm_idx];

    assign is_bx        = (instr[27:20] == 8'b0001_0010) && (instr[7:4] == 4'b0001);
    assign is_dp        = (instr[27:26] == 2'b00) && !is_bx && (instr[25] || !instr[4]);
    assign is_mem       = (instr[27:26] == 2'b01);
    assign is_br        = (instr[27:25] == 3'b101);
    assign is_swi       = (instr[27:24] == 4'b1111);
    assign is_cmp_class = (instr[24:23] == 2'b10);
    assign take_fiq     = firq && !f_q;
    assign take_irq     = irq && !i_q && !take_fiq;

    always_comb begin
        cond_ok = 1'b0;
        unique case (instr[31:28])
            4'h0: cond_ok = z_q;
            4'h1: cond_ok = !z_q;
            4'h2: cond_ok = c_q;
            4'h3: cond_ok = !c_q;
            4'h4: cond_ok = n_q;
            4'h5: cond_ok = !n_q;
            4'h6: cond_ok = v_q;
            4'h7: cond_ok = !v_q;
            4'h8: cond_ok = c_q && !z_q;
            4'h9: cond_ok = !c_q || z_q;
            4'hA: cond_ok = (n_q == v_q);
            4'hB: cond_ok = (n_q != v_q);
            4'hC: cond_ok = !z_q && (n_q == v_q);
            4'hD: cond_ok = z_q || (n_q != v_q);
            4'hE: cond_ok = 1'b1;
            4'hF: cond_ok = 1'b0;
        endcase
    end

    // Operand2 barrel shifter with the shift-by-zero encodings (LSR/ASR #32, RRX)
    always_comb begin
        imm32  = {24'd0, instr[7:0]};
        rot    = {instr[11:8], 1'b0};
        shamt  = instr[11:7];
        sh_tmp = '0;
        op2    = rm_val;
        sh_c   = c_q;
        if (instr[25]) begin
            op2  = (imm32 >> rot) | (imm32 << (6'd32 - {1'b0, rot}));
            sh_c = (rot == 5'd0) ? c_q : op2[31];
        end else begin
            unique case (instr[6:5])
                2'b00: begin
                    if (shamt != 5'd0) begin
                        sh_tmp = {1'b0, rm_val} << shamt;
                        op2    = sh_tmp[31:0];
                        sh_c   = sh_tmp[32];
                    end
                end
                2'b01: begin
                    if (shamt == 5'd0) begin
                        op2  = '0;
                        sh_c = rm_val[31];
                    end else begin
                        sh_tmp = {rm_val, 1'b0} >> shamt;
                        op2    = sh_tmp[32:1];
                        sh_c   = sh_tmp[0];
                    end
                end
                2'b10: begin
                    if (shamt == 5'd0) begin
                        op2  = {XLEN{rm_val[31]}};
                        sh_c = rm_val[31];
                    end else begin
                        sh_tmp = 33'($signed({rm_val, 1'b0}) >>> shamt);
                        op2    = sh_tmp[32:1];
                        sh_c   = sh_tmp[0];
                    end
                end
                2'b11: begin
                    if (shamt == 5'd0) begin
                        op2  = {c_q, rm_val[31:1]};
                        sh_c = rm_val[0];
                    end else begin
                        op2  = (rm_val >> shamt) | (rm_val << (6'd32 - {1'b0, shamt}));
                        sh_c = op2[31];
                    end
                end
            endcase
        end
    end

    // Shared adder: subtraction is x + ~y + cin, so carry out means "no borrow"
    always_comb begin
        alu_op    = alu_op_e'(instr[24:21]);
        add_x     = rn_val;
        add_y     = op2;
        add_cin   = 1'b0;
        arith     = 1'b0;
        logic_res = '0;
        unique case (alu_op)
            OP_AND, OP_TST: logic_res = rn_val & op2;
            OP_EOR, OP_TEQ: logic_res = rn_val ^ op2;
            OP_SUB, OP_CMP: begin add_y = ~op2; add_cin = 1'b1; arith = 1'b1; end
            OP_RSB:         begin add_x = op2; add_y = ~rn_val; add_cin = 1'b1; arith = 1'b1; end
            OP_ADD, OP_CMN: arith = 1'b1;
            OP_ADC:         begin add_cin = c_q; arith = 1'b1; end
            OP_SBC:         begin add_y = ~op2; add_cin = c_q; arith = 1'b1; end
            OP_RSC:         begin add_x = op2; add_y = ~rn_val; add_cin = c_q; arith = 1'b1; end
            OP_ORR:         logic_res = rn_val | op2;
            OP_MOV:         logic_res = op2;
            OP_BIC:         logic_res = rn_val & ~op2;
            OP_MVN:         logic_res = ~op2;
        endcase
        sum     = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
        alu_res = arith ? sum[31:0] : logic_res;
        alu_c   = arith ? sum[32] : sh_c;
        alu_v   = arith ? ((add_x[31] == add_y[31]) && (sum[31] != add_x[31])) : v_q;
    end

    assign mem_addr   = instr[23] ? (rn_val + {20'd0, instr[11:0]})
                                  : (rn_val - {20'd0, instr[11:0]});
    assign pc         = pc_q;
    assign addr_data  = is_mem ? mem_addr : alu_res;
    assign write_data = rd_val;
    assign we         = !reset && cond_ok && is_mem && !instr[20] && !take_fiq && !take_irq;

    // Next state: a taken interrupt suppresses the instruction, so one register write port suffices
    always_comb begin
        pc_d   = pc_plus4;
        n_d    = n_q;
        z_d    = z_q;
        c_d    = c_q;
        v_d    = v_q;
        i_d    = i_q;
        f_d    = f_q;
        wr_en  = 1'b0;
        wr_idx = rd_idx;
        wr_val = alu_res;
        if (take_fiq) begin
            wr_en  = 1'b1;
            wr_idx = REG_LR;
            wr_val = pc_plus4;
            pc_d   = VEC_FIQ;
            f_d    = 1'b1;
            i_d    = 1'b1;
        end else if (take_irq) begin
            wr_en  = 1'b1;
            wr_idx = REG_LR;
            wr_val = pc_plus4;
            pc_d   = VEC_IRQ;
            i_d    = 1'b1;
        end else if (cond_ok) begin
            if (is_bx) begin
                pc_d = {rm_val[31:1], 1'b0};
            end else if (is_dp) begin
                if (instr[20] || is_cmp_class) begin
                    n_d = alu_res[31];
                    z_d = (alu_res == '0);
                    c_d = alu_c;
                    v_d = alu_v;
                end
                if (!is_cmp_class) begin
                    if (rd_idx == REG_PC) begin
                        pc_d = alu_res;
                        if (instr[20]) begin
                            i_d = 1'b0;
                            f_d = 1'b0;
                        end
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end else if (is_mem) begin
                if (instr[20]) begin
                    if (rd_idx == REG_PC) begin
                        pc_d = read_data;
                    end else begin
                        wr_en  = 1'b1;
                        wr_val = read_data;
                    end
                end
            end else if (is_br) begin
                pc_d = pc_plus8 + {{6{instr[23]}}, instr[23:0], 2'b00};
                if (instr[24]) begin
                    wr_en  = 1'b1;
                    wr_idx = REG_LR;
                    wr_val = pc_plus4;
                end
            end else if (is_swi) begin
                wr_en  = 1'b1;
                wr_idx = REG_LR;
                wr_val = pc_plus4;
                pc_d   = VEC_SWI;
                i_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
            n_q  <= 1'b0;
            z_q  <= 1'b1;
            c_q  <= 1'b0;
            v_q  <= 1'b0;
            i_q  <= 1'b0;
            f_q  <= 1'b0;
        end else begin
            pc_q <= pc_d;
            n_q  <= n_d;
            z_q  <= z_d;
            c_q  <= c_d;
            v_q  <= v_d;
            i_q  <= i_d;
            f_q  <= f_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[wr_idx] <= wr_val;
        end
    end

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: expectations are queued as each instruction is driven and
// compared mid-cycle against the combinational outputs and the pc of that cycle.
module tb_data_path;

    localparam int SEL_PC = 0;
    localparam int SEL_WE = 1;
    localparam int SEL_AD = 2;
    localparam int SEL_WD = 3;

    logic        clk, reset, irq, firq, we;
    logic [31:0] instr, read_data, pc, addr_data, write_data;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    data_path dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .read_data (read_data),
        .irq       (irq),
        .firq      (firq),
        .pc        (pc),
        .addr_data (addr_data),
        .write_data(write_data),
        .we        (we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_PC:  return pc;
            SEL_WE:  return {31'd0, we};
            SEL_AD:  return addr_data;
            default: return write_data;
        endcase
    endfunction

    // Never-condition instruction whose Rd field exposes a register on write_data
    function automatic logic [31:0] probe(input int r);
        return 32'hF000_0000 | (32'(r) << 12);
    endfunction

    task automatic want(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] rd,
                        input logic ir, input logic fi);
        instr     = ins;
        read_data = rd;
        irq       = ir;
        firq      = fi;
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #10000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset     = 1'b0;
        instr     = 32'hE405_301A;
        read_data = '0;
        irq       = 1'b0;
        firq      = 1'b0;
        #1 reset  = 1'b1;
        #1;
        want("rst_pc", SEL_PC, 32'h0);
        want("rst_we", SEL_WE, 32'h0);
        check_all();
        @(posedge clk);
        #1 reset = 1'b0;

        want("mov_pc", SEL_PC, 32'h0);   want("mov_ad", SEL_AD, 32'h2);
        want("mov_wd", SEL_WD, 32'h0);   want("mov_we", SEL_WE, 32'h0);
        step(32'h03A0_3002, '0, 1'b0, 1'b0);
        want("add_pc", SEL_PC, 32'h4);   want("add_ad", SEL_AD, 32'h3);
        want("add_wd", SEL_WD, 32'h2);
        step(32'h0283_3001, '0, 1'b0, 1'b0);
        want("str_pc", SEL_PC, 32'h8);   want("str_we", SEL_WE, 32'h1);
        want("str_ad", SEL_AD, 32'hFFFF_FFE6); want("str_wd", SEL_WD, 32'h3);
        step(32'hE405_301A, '0, 1'b0, 1'b0);
        want("ldr_pc", SEL_PC, 32'hC);   want("ldr_we", SEL_WE, 32'h0);
        want("ldr_ad", SEL_AD, 32'hFFFF_FFE6);
        step(32'hE415_301A, 32'hDEAD_BEEF, 1'b0, 1'b0);
        want("ne_pc", SEL_PC, 32'h10);   want("ldr_r3", SEL_WD, 32'hDEAD_BEEF);
        step(32'h1283_3001, '0, 1'b0, 1'b0);
        want("ne_nop_pc", SEL_PC, 32'h14); want("ne_nop_r3", SEL_WD, 32'hDEAD_BEEF);
        step(probe(3), '0, 1'b0, 1'b0);

        want("b_pc", SEL_PC, 32'h18);
        step(32'hEA00_0100, '0, 1'b0, 1'b0);
        want("bl_pc", SEL_PC, 32'h420);
        step(32'hEB00_0200, '0, 1'b0, 1'b0);
        want("bx_pc", SEL_PC, 32'hC28);
        step(32'h0120_001E, '0, 1'b0, 1'b0);
        want("bx_ret_pc", SEL_PC, 32'h424); want("bl_lr", SEL_WD, 32'h424);
        step(probe(14), '0, 1'b0, 1'b0);
        want("movpc_pc", SEL_PC, 32'h428); want("movpc_ad", SEL_AD, 32'h100);
        step(32'hE3A0_FC01, '0, 1'b0, 1'b0);

        want("swi_pc", SEL_PC, 32'h100);
        step(32'h0F00_0000, '0, 1'b0, 1'b0);
        want("swi_vec", SEL_PC, 32'h8);  want("swi_lr", SEL_WD, 32'h104);
        step(probe(14), '0, 1'b1, 1'b0);
        want("irq_masked_pc", SEL_PC, 32'hC); want("movs_ad", SEL_AD, 32'h104);
        step(32'h01B0_F00E, '0, 1'b1, 1'b0);
        want("movs_pc", SEL_PC, 32'h104); want("irq_we", SEL_WE, 32'h0);
        step(32'hE405_301A, '0, 1'b1, 1'b0);
        want("irq_vec", SEL_PC, 32'h18); want("irq_lr", SEL_WD, 32'h108);
        step(probe(14), '0, 1'b0, 1'b0);
        want("ret_pc", SEL_PC, 32'h1C);
        step(32'hE1B0_F00E, '0, 1'b0, 1'b0);
        want("fiq_pc", SEL_PC, 32'h108);
        step(32'hE3A0_3002, '0, 1'b1, 1'b1);
        want("fiq_vec", SEL_PC, 32'h1C); want("fiq_r3", SEL_WD, 32'hDEAD_BEEF);
        step(probe(3), '0, 1'b1, 1'b1);
        want("fiq_masked_pc", SEL_PC, 32'h20); want("fiq_lr", SEL_WD, 32'h10C);
        step(probe(14), '0, 1'b0, 1'b0);

        want("subs_ad", SEL_AD, 32'hFFFF_FFFF);
        step(32'hE250_4001, '0, 1'b0, 1'b0);
        want("mi_ad", SEL_AD, 32'h7);
        step(32'h43A0_5007, '0, 1'b0, 1'b0);
        step(32'h23A0_5009, '0, 1'b0, 1'b0);
        want("cs_fail_r5", SEL_WD, 32'h7); want("cs_fail_pc", SEL_PC, 32'h30);
        step(probe(5), '0, 1'b0, 1'b0);
        want("lsl_ad", SEL_AD, 32'h3F);
        step(32'hE085_6185, '0, 1'b0, 1'b0);
        want("lsr32_ad", SEL_AD, 32'h0);
        step(32'hE1B0_7024, '0, 1'b0, 1'b0);
        step(32'h83A0_8001, '0, 1'b0, 1'b0);
        step(32'h93A0_8002, '0, 1'b0, 1'b0);
        want("ls_r8", SEL_WD, 32'h2);    want("ls_pc", SEL_PC, 32'h44);
        step(probe(8), '0, 1'b0, 1'b0);
        want("regshift_pc", SEL_PC, 32'h48);
        step(32'hE085_8015, '0, 1'b0, 1'b0);
        want("regshift_r8", SEL_WD, 32'h2); want("regshift_nxt", SEL_PC, 32'h4C);
        step(probe(8), '0, 1'b0, 1'b0);

        instr = 32'hE405_301A;
        want("str2_we", SEL_WE, 32'h1);  want("str2_ad", SEL_AD, 32'hFFFF_FFED);
        want("str2_wd", SEL_WD, 32'hDEAD_BEEF);
        @(negedge clk);
        check_all();
        #2 reset = 1'b1;
        #1;
        want("midrst_pc", SEL_PC, 32'h0); want("midrst_we", SEL_WE, 32'h0);
        check_all();
        @(posedge clk);
        #1 reset = 1'b0;
        want("post_rst_pc", SEL_PC, 32'h0); want("post_rst_r3", SEL_WD, 32'h0);
        step(probe(3), '0, 1'b0, 1'b0);
        step(32'h03A0_3005, '0, 1'b0, 1'b0);
        want("post_rst_eq", SEL_WD, 32'h5); want("post_rst_pc8", SEL_PC, 32'h8);
        step(probe(3), '0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
